// File: rtl/snake_body_engine.sv
// Snake body store with move/grow/collision FSM and a registered segment read port.
// Define SNAKE_WRAP_EN to make the grid edges wrap around instead of killing the snake.
module snake_body_engine #(
  parameter  int GRID_W   = 64,
  parameter  int GRID_H   = 48,
  parameter  int MAX_LEN  = 128,
  parameter  int INIT_LEN = 3,
  parameter  int GROW     = 5,
  localparam int X_W      = $clog2(GRID_W),
  localparam int Y_W      = $clog2(GRID_H),
  localparam int LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             tick,
  input  logic             dir_valid,
  input  logic [1:0]       dir,
  input  logic             grow,
  input  logic [LEN_W-1:0] rd_idx,
  output logic [X_W-1:0]   rd_x,
  output logic [Y_W-1:0]   rd_y,
  output logic             rd_vld,
  output logic [X_W-1:0]   head_x,
  output logic [Y_W-1:0]   head_y,
  output logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             dead,
  output logic             hit_self,
  output logic             hit_wall
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int PW    = LEN_W + 1;

`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_MOVE  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DEAD  = 3'd4
  } state_t;

  localparam logic [1:0]       DIR_UP    = 2'd0;
  localparam logic [1:0]       DIR_RIGHT = 2'd1;
  localparam logic [1:0]       DIR_DOWN  = 2'd2;
  localparam logic [1:0]       DIR_LEFT  = 2'd3;
  localparam logic [X_W-1:0]   X_MAX     = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]   Y_MAX     = Y_W'(GRID_H - 1);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
  localparam logic [PW-1:0]    PEND_MAX  = PW'(MAX_LEN);

  state_t           state_r;
  logic [X_W-1:0]   seg_x_r [MAX_LEN];
  logic [Y_W-1:0]   seg_y_r [MAX_LEN];
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] pending_r;
  logic [LEN_W-1:0] k_r;
  logic [1:0]       cur_dir_r;
  logic [1:0]       req_dir_r;
  logic             busy_r;
  logic             dead_r;
  logic             hit_self_r;
  logic             hit_wall_r;
  logic [X_W-1:0]   rd_x_r;
  logic [Y_W-1:0]   rd_y_r;
  logic             rd_vld_r;

  logic [X_W-1:0]   step_x_s;
  logic [Y_W-1:0]   step_y_s;
  logic             wall_s;
  logic [PW-1:0]    pend_sum_s;
  logic [LEN_W-1:0] pend_in_s;
  logic [IDX_W-1:0] k_idx_s;
  logic [IDX_W-1:0] rd_sel_s;
  logic             rd_in_s;

  assign k_idx_s  = k_r[IDX_W-1:0];
  assign rd_sel_s = rd_idx[IDX_W-1:0];
  assign rd_in_s  = (rd_idx < len_r);

  // Next head cell for cur_dir; at an edge the step lands on the wrapped cell.
  always_comb begin
    step_x_s = seg_x_r[0];
    step_y_s = seg_y_r[0];
    wall_s   = 1'b0;
    case (cur_dir_r)
      DIR_UP: begin
        if (seg_y_r[0] == {Y_W{1'b0}}) begin
          step_y_s = Y_MAX;
          wall_s   = ~WRAP;
        end else begin
          step_y_s = seg_y_r[0] - Y_W'(1);
        end
      end
      DIR_RIGHT: begin
        if (seg_x_r[0] == X_MAX) begin
          step_x_s = {X_W{1'b0}};
          wall_s   = ~WRAP;
        end else begin
          step_x_s = seg_x_r[0] + X_W'(1);
        end
      end
      DIR_DOWN: begin
        if (seg_y_r[0] == Y_MAX) begin
          step_y_s = {Y_W{1'b0}};
          wall_s   = ~WRAP;
        end else begin
          step_y_s = seg_y_r[0] + Y_W'(1);
        end
      end
      DIR_LEFT: begin
        if (seg_x_r[0] == {X_W{1'b0}}) begin
          step_x_s = X_MAX;
          wall_s   = ~WRAP;
        end else begin
          step_x_s = seg_x_r[0] - X_W'(1);
        end
      end
      default: begin
        step_x_s = seg_x_r[0];
        step_y_s = seg_y_r[0];
        wall_s   = 1'b0;
      end
    endcase
  end

  // Pending growth after accepting a food pulse, saturated at the segment capacity.
  always_comb begin
    pend_sum_s = PW'(pending_r) + PW'(GROW);
    if (grow && ((state_r == ST_RUN) || (state_r == ST_MOVE) || (state_r == ST_CHECK))) begin
      if (pend_sum_s > PEND_MAX) begin
        pend_in_s = LEN_MAX;
      end else begin
        pend_in_s = pend_sum_s[LEN_W-1:0];
      end
    end else begin
      pend_in_s = pending_r;
    end
  end

  // Game FSM: start/init, direction latch, body shift with growth, collision scan.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_r[i] <= {X_W{1'b0}};
        seg_y_r[i] <= {Y_W{1'b0}};
      end
      len_r      <= {LEN_W{1'b0}};
      pending_r  <= {LEN_W{1'b0}};
      k_r        <= {LEN_W{1'b0}};
      cur_dir_r  <= DIR_RIGHT;
      req_dir_r  <= DIR_RIGHT;
      busy_r     <= 1'b0;
      dead_r     <= 1'b0;
      hit_self_r <= 1'b0;
      hit_wall_r <= 1'b0;
    end else if (start) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) begin
          seg_x_r[i] <= X_W'(GRID_W / 2 - i);
          seg_y_r[i] <= Y_W'(GRID_H / 2);
        end else begin
          seg_x_r[i] <= {X_W{1'b0}};
          seg_y_r[i] <= {Y_W{1'b0}};
        end
      end
      len_r      <= LEN_W'(INIT_LEN);
      pending_r  <= {LEN_W{1'b0}};
      k_r        <= {LEN_W{1'b0}};
      cur_dir_r  <= DIR_RIGHT;
      req_dir_r  <= DIR_RIGHT;
      busy_r     <= 1'b0;
      dead_r     <= 1'b0;
      hit_self_r <= 1'b0;
      hit_wall_r <= 1'b0;
      state_r    <= ST_RUN;
    end else begin
      // A request for the exact reverse of the current heading is dropped.
      if (dir_valid && (dir != (cur_dir_r ^ 2'd2))) begin
        req_dir_r <= dir;
      end
      pending_r <= pend_in_s;
      case (state_r)
        ST_RUN: begin
          if (tick) begin
            cur_dir_r <= req_dir_r;
            busy_r    <= 1'b1;
            state_r   <= ST_MOVE;
          end
        end
        ST_MOVE: begin
          if (wall_s) begin
            hit_wall_r <= 1'b1;
            dead_r     <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= ST_DEAD;
          end else begin
            seg_x_r[0] <= step_x_s;
            seg_y_r[0] <= step_y_s;
            for (int i = 1; i < MAX_LEN; i++) begin
              seg_x_r[i] <= seg_x_r[i-1];
              seg_y_r[i] <= seg_y_r[i-1];
            end
            if ((pending_r != {LEN_W{1'b0}}) && (len_r < LEN_MAX)) begin
              len_r     <= len_r + LEN_W'(1);
              pending_r <= pend_in_s - LEN_W'(1);
            end else if (len_r == LEN_MAX) begin
              pending_r <= {LEN_W{1'b0}};
            end else begin
              pending_r <= pend_in_s;
            end
            k_r     <= LEN_W'(1);
            state_r <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (k_r >= len_r) begin
            busy_r  <= 1'b0;
            state_r <= ST_RUN;
          end else if ((seg_x_r[k_idx_s] == seg_x_r[0]) && (seg_y_r[k_idx_s] == seg_y_r[0])) begin
            hit_self_r <= 1'b1;
            dead_r     <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= ST_DEAD;
          end else if (k_r == (len_r - LEN_W'(1))) begin
            busy_r  <= 1'b0;
            state_r <= ST_RUN;
          end else begin
            k_r <= k_r + LEN_W'(1);
          end
        end
        default: begin
          state_r <= state_r;
        end
      endcase
    end
  end

  // Renderer read port, one cycle latency, zero outside the live body.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_x_r   <= {X_W{1'b0}};
      rd_y_r   <= {Y_W{1'b0}};
      rd_vld_r <= 1'b0;
    end else if (rd_in_s) begin
      rd_x_r   <= seg_x_r[rd_sel_s];
      rd_y_r   <= seg_y_r[rd_sel_s];
      rd_vld_r <= 1'b1;
    end else begin
      rd_x_r   <= {X_W{1'b0}};
      rd_y_r   <= {Y_W{1'b0}};
      rd_vld_r <= 1'b0;
    end
  end

  assign rd_x     = rd_x_r;
  assign rd_y     = rd_y_r;
  assign rd_vld   = rd_vld_r;
  assign head_x   = seg_x_r[0];
  assign head_y   = seg_y_r[0];
  assign len      = len_r;
  assign busy     = busy_r;
  assign dead     = dead_r;
  assign hit_self = hit_self_r;
  assign hit_wall = hit_wall_r;

endmodule

// File: tb/tb_snake_body_engine.sv
// Self-checking bench for snake_body_engine: directed scenarios plus a randomized run
// compared against a queue-based model of the snake body.
module tb_snake_body_engine;

  localparam int GRID_W  = 64;
  localparam int GRID_H  = 48;
  localparam int MAX_LEN = 128;
  localparam int GROW_N  = 5;
  localparam int X_W     = 6;
  localparam int Y_W     = 6;
  localparam int LEN_W   = 8;

  logic             clk = 1'b0;
  logic             reset, start, tick, dir_valid, grow;
  logic [1:0]       dir;
  logic [LEN_W-1:0] rd_idx;
  logic [X_W-1:0]   rd_x, head_x;
  logic [Y_W-1:0]   rd_y, head_y;
  logic [LEN_W-1:0] len;
  logic             rd_vld, busy, dead, hit_self, hit_wall;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: body as queues (index 0 = head)
  int mx[$];
  int my[$];
  int m_pending, m_cur, m_req;
  bit m_started, m_dead, m_wall, m_self;

  snake_body_engine dut (
    .clk(clk), .reset(reset), .start(start), .tick(tick), .dir_valid(dir_valid),
    .dir(dir), .grow(grow), .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_vld(rd_vld),
    .head_x(head_x), .head_y(head_y), .len(len), .busy(busy), .dead(dead),
    .hit_self(hit_self), .hit_wall(hit_wall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    mx.delete(); my.delete();
    m_pending = 0; m_cur = 1; m_req = 1;
    m_started = 0; m_dead = 0; m_wall = 0; m_self = 0;
  endtask

  task automatic model_start();
    model_clear();
    for (int i = 0; i < 3; i++) begin
      mx.push_back(GRID_W / 2 - i);
      my.push_back(GRID_H / 2);
    end
    m_started = 1;
  endtask

  task automatic model_dir(input int d);
    if (d != (m_cur + 2) % 4) m_req = d;
  endtask

  task automatic model_grow();
    if (m_started && !m_dead) begin
      m_pending = m_pending + GROW_N;
      if (m_pending > MAX_LEN) m_pending = MAX_LEN;
    end
  endtask

  task automatic model_tick();
    int nx, ny;
    bit grows, hit;
    if (!m_started || m_dead) return;
    m_cur = m_req;
    nx = mx[0];
    ny = my[0];
    case (m_cur)
      0: ny = ny - 1;
      1: nx = nx + 1;
      2: ny = ny + 1;
      default: nx = nx - 1;
    endcase
`ifdef SNAKE_WRAP_EN
    nx = (nx + GRID_W) % GRID_W;
    ny = (ny + GRID_H) % GRID_H;
`else
    if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) begin
      m_dead = 1;
      m_wall = 1;
      return;
    end
`endif
    grows = (m_pending > 0) && (mx.size() < MAX_LEN);
    if (grows) m_pending = m_pending - 1;
    else if (mx.size() == MAX_LEN) m_pending = 0;
    if (!grows) begin
      void'(mx.pop_back());
      void'(my.pop_back());
    end
    hit = 0;
    for (int i = 0; i < mx.size(); i++) if (mx[i] == nx && my[i] == ny) hit = 1;
    mx.push_front(nx);
    my.push_front(ny);
    if (hit) begin
      m_dead = 1;
      m_self = 1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    model_start();
  endtask

  task automatic do_dir(input int d);
    dir_valid = 1'b1;
    dir = 2'(d);
    step();
    dir_valid = 1'b0;
    model_dir(d);
  endtask

  // Tick (optionally with food) and wait for busy to drop; reports busy length.
  task automatic do_move(input bit g, output int busy_cnt, output int head_at_move);
    tick = 1'b1;
    grow = g;
    if (g) model_grow();
    model_tick();
    step();
    tick = 1'b0;
    grow = 1'b0;
    head_at_move = int'({head_x, head_y});
    busy_cnt = 0;
    while (busy === 1'b1 && busy_cnt < 300) begin
      busy_cnt++;
      step();
    end
    tests_run++;
    if (busy_cnt >= 300) begin
      tests_failed++;
      $display("FAIL move_timeout: busy still %b after %0d cycles, required 0", busy, busy_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; tick = 1'b0; dir_valid = 1'b0; dir = 2'd0;
    grow = 1'b0; rd_idx = '0;
    model_clear();
    repeat (2) step();
    reset = 1'b0;
    step();
    tests_run++;
    if ({head_x, head_y, len, busy, dead, hit_self, hit_wall, rd_vld, rd_x, rd_y} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: head=(%0d,%0d) len=%0d busy=%b dead=%b hs=%b hw=%b rv=%b, required all 0",
               head_x, head_y, len, busy, dead, hit_self, hit_wall, rd_vld);
    end
  endtask

  task automatic test_start();
    int ex[3] = '{32, 31, 30};
    do_start();
    tests_run++;
    if (head_x !== 6'd32 || head_y !== 6'd24 || len !== 8'd3 || dead !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_state: head=(%0d,%0d) len=%0d dead=%b busy=%b, required (32,24) 3 0 0",
               head_x, head_y, len, dead, busy);
    end
    for (int i = 0; i < 4; i++) begin
      rd_idx = LEN_W'(i);
      step();
      tests_run++;
      if (i < 3 && (rd_vld !== 1'b1 || int'(rd_x) != ex[i] || rd_y !== 6'd24)) begin
        tests_failed++;
        $display("FAIL start_seg%0d: got (%0d,%0d) vld=%b, required (%0d,24) vld=1", i, rd_x, rd_y, rd_vld, ex[i]);
      end else if (i == 3 && {rd_vld, rd_x, rd_y} !== '0) begin
        tests_failed++;
        $display("FAIL start_seg_oob: got (%0d,%0d) vld=%b, required (0,0) vld=0", rd_x, rd_y, rd_vld);
      end
    end
  endtask

  task automatic test_straight();
    int bc, hm;
    for (int t = 0; t < 4; t++) begin
      do_move(1'b0, bc, hm);
      tests_run++;
      if (bc != 3) begin
        tests_failed++;
        $display("FAIL straight_busy: busy for %0d cycles, required 3", bc);
      end
      tests_run++;
      if (hm != (((32 + t) << Y_W) | 24)) begin
        tests_failed++;
        $display("FAIL straight_head_latency: head during MOVE x=%0d, required old x=%0d", hm >> Y_W, 32 + t);
      end
    end
    tests_run++;
    if (head_x !== 6'd36 || head_y !== 6'd24 || len !== 8'd3) begin
      tests_failed++;
      $display("FAIL straight_end: head=(%0d,%0d) len=%0d, required (36,24) 3", head_x, head_y, len);
    end
  endtask

  task automatic test_reversal();
    int bc, hm;
    do_start();
    do_dir(3);
    do_dir(0);
    do_move(1'b0, bc, hm);
    tests_run++;
    if (head_x !== 6'd32 || head_y !== 6'd23) begin
      tests_failed++;
      $display("FAIL reversal_up: head=(%0d,%0d), required (32,23)", head_x, head_y);
    end
    do_dir(2);
    do_move(1'b0, bc, hm);
    tests_run++;
    if (head_x !== 6'd32 || head_y !== 6'd22 || dead !== 1'b0) begin
      tests_failed++;
      $display("FAIL reversal_down: head=(%0d,%0d) dead=%b, required (32,22) 0", head_x, head_y, dead);
    end
  endtask

  task automatic test_grow();
    int bc, hm;
    do_start();
    grow = 1'b1;
    model_grow();
    step();
    grow = 1'b0;
    for (int t = 0; t < 6; t++) begin
      do_move(1'b0, bc, hm);
      tests_run++;
      if (int'(len) != ((t < 5) ? 4 + t : 8) || bc != int'(len)) begin
        tests_failed++;
        $display("FAIL grow_len%0d: len=%0d busy=%0d, required len=%0d busy=len", t, len, bc, (t < 5) ? 4 + t : 8);
      end
    end
  endtask

  task automatic test_wall();
    int bc, hm;
    do_start();
    for (int t = 0; t < 32; t++) do_move(1'b0, bc, hm);
`ifdef SNAKE_WRAP_EN
    tests_run++;
    if (head_x !== 6'd0 || head_y !== 6'd24 || dead !== 1'b0 || hit_wall !== 1'b0) begin
      tests_failed++;
      $display("FAIL wall_wrap: head=(%0d,%0d) dead=%b hw=%b, required (0,24) 0 0", head_x, head_y, dead, hit_wall);
    end
`else
    tests_run++;
    if (head_x !== 6'd63 || head_y !== 6'd24 || dead !== 1'b1 || hit_wall !== 1'b1 || hit_self !== 1'b0) begin
      tests_failed++;
      $display("FAIL wall_hit: head=(%0d,%0d) dead=%b hw=%b hs=%b, required (63,24) 1 1 0",
               head_x, head_y, dead, hit_wall, hit_self);
    end
    do_move(1'b0, bc, hm);
    tests_run++;
    if (bc != 0 || head_x !== 6'd63 || dead !== 1'b1) begin
      tests_failed++;
      $display("FAIL dead_tick: busy=%0d head_x=%0d dead=%b, required 0 63 1", bc, head_x, dead);
    end
`endif
  endtask

  task automatic test_self();
    int bc, hm;
    do_start();
    do_move(1'b1, bc, hm);
    for (int t = 0; t < 4; t++) do_move(1'b0, bc, hm);
    tests_run++;
    if (len !== 8'd8) begin
      tests_failed++;
      $display("FAIL self_len: len=%0d, required 8", len);
    end
    do_dir(0); do_move(1'b0, bc, hm);
    do_dir(3); do_move(1'b0, bc, hm);
    do_dir(2); do_move(1'b0, bc, hm);
    tests_run++;
    if (hit_self !== 1'b1 || dead !== 1'b1 || hit_wall !== 1'b0 || head_x !== 6'd36 || head_y !== 6'd24 || !m_self) begin
      tests_failed++;
      $display("FAIL self_hit: hs=%b dead=%b hw=%b head=(%0d,%0d), required 1 1 0 (36,24)",
               hit_self, dead, hit_wall, head_x, head_y);
    end
    do_start();
    tests_run++;
    if (hit_self !== 1'b0 || hit_wall !== 1'b0 || dead !== 1'b0 || len !== 8'd3) begin
      tests_failed++;
      $display("FAIL self_restart: hs=%b hw=%b dead=%b len=%0d, required 0 0 0 3", hit_self, hit_wall, dead, len);
    end
  endtask

  task automatic test_abort();
    do_start();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    model_start();
    tests_run++;
    if (busy !== 1'b0 || head_x !== 6'd32 || len !== 8'd3) begin
      tests_failed++;
      $display("FAIL abort_start: busy=%b head_x=%0d len=%0d, required 0 32 3", busy, head_x, len);
    end
  endtask

  task automatic test_reset_mid();
    int bc, hm;
    tick = 1'b1;
    step();
    tick = 1'b0;
    reset = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || len !== 8'd0 || head_x !== 6'd0 || dead !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: busy=%b len=%0d head_x=%0d dead=%b, required 0 0 0 0", busy, len, head_x, dead);
    end
    step();
    reset = 1'b0;
    model_clear();
    do_move(1'b0, bc, hm);
    tests_run++;
    if (bc != 0 || head_x !== 6'd0 || len !== 8'd0) begin
      tests_failed++;
      $display("FAIL idle_tick: busy=%0d head_x=%0d len=%0d, required 0 0 0", bc, head_x, len);
    end
  endtask

  task automatic test_random();
    int bc, hm, idx, bad;
    bit g;
    do_start();
    for (int n = 0; n < 300; n++) begin
      if (m_dead) do_start();
      if ($urandom_range(0, 2) == 0) do_dir(int'($urandom_range(0, 3)));
      g = ($urandom_range(0, 7) == 0);
      do_move(g, bc, hm);
      tests_run++;
      if (int'(head_x) != mx[0] || int'(head_y) != my[0] || int'(len) != mx.size() ||
          dead !== m_dead || hit_wall !== m_wall || hit_self !== m_self ||
          (!m_dead && bc != mx.size())) begin
        tests_failed++;
        $display("FAIL rand_move%0d: head=(%0d,%0d) len=%0d dead=%b hw=%b hs=%b busy=%0d, required (%0d,%0d) %0d %b %b %b",
                 n, head_x, head_y, len, dead, hit_wall, hit_self, bc, mx[0], my[0], mx.size(), m_dead, m_wall, m_self);
      end
      idx = int'($urandom_range(0, mx.size() + 1));
      rd_idx = LEN_W'(idx);
      step();
      bad = (idx < mx.size()) ? (rd_vld !== 1'b1 || int'(rd_x) != mx[idx] || int'(rd_y) != my[idx])
                              : ({rd_vld, rd_x, rd_y} !== '0);
      tests_run++;
      if (bad != 0) begin
        tests_failed++;
        $display("FAIL rand_read%0d: idx=%0d got (%0d,%0d) vld=%b", n, idx, rd_x, rd_y, rd_vld);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_straight();
    test_reversal();
    test_grow();
    test_wall();
    test_self();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/snake_body_engine.md
# snake_body_engine

Parametrised snake-body engine for the snake game: stores up to MAX_LEN body segments on a GRID_W x GRID_H grid, advances the body one cell per move strobe, applies a latched direction with reversal rejection, handles delayed growth, and detects self and wall collisions. It sits between the divided game-tick/button logic in `snake_top` and the VGA renderer, which reads segments through a registered read port.

## Interface
- GRID_W, 64, grid columns; X_W = $clog2(GRID_W)
- GRID_H, 48, grid rows; Y_W = $clog2(GRID_H)
- MAX_LEN, 128, segment capacity; LEN_W = $clog2(MAX_LEN+1)
- INIT_LEN, 3, length after start (2..MAX_LEN)
- GROW, 5, segments added per food event
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clock clk
- start  in  1  pulse: (re)initialise snake, enter RUN
- tick  in  1  one-cycle move strobe (from clock divider)
- dir_valid  in  1  dir is a new direction request
- dir  in  2  0=up(y-1) 1=right(x+1) 2=down(y+1) 3=left(x-1)
- grow  in  1  pulse: food eaten
- rd_idx  in  LEN_W  segment index for renderer (0 = head)
- rd_x / rd_y  out  X_W / Y_W  segment coordinates, registered
- rd_vld  out  1  registered, rd_idx < len
- head_x / head_y  out  X_W / Y_W  current head
- len  out  LEN_W  current length
- busy  out  1  state is MOVE or CHECK
- dead  out  1  state is DEAD
- hit_self / hit_wall  out  1  sticky cause flags, cleared by start

## Operation
- States: IDLE, RUN, MOVE, CHECK, DEAD. Reset -> IDLE; all outputs 0, arrays cleared, cur_dir=right, pending=0.
- start (any state, highest priority): one cycle; segment i = (GRID_W/2 - i, GRID_H/2) for i < INIT_LEN; len=INIT_LEN; cur_dir=right; pending=0; flags cleared; -> RUN.
- Direction: dir_valid in any state latches req_dir unless dir is the exact reverse of cur_dir (ignored). req_dir becomes cur_dir on MOVE entry.
- grow: pending += GROW, saturating at MAX_LEN. grow coincident with tick counts for that move.
- RUN + tick -> MOVE (one cycle): new head = segment0 stepped by cur_dir; segment i <= segment i-1 for all i in parallel; if pending>0 and len<MAX_LEN, len+1, pending-1; at len=MAX_LEN, pending is discarded. -> CHECK.
- Wall (no wrap): stepping off 0 or GRID_W-1/GRID_H-1 sets hit_wall, body not shifted, -> DEAD.
- CHECK: index k scans 1..len-1, one segment per cycle, compared to head; match sets hit_self, -> DEAD immediately; scan end -> RUN. Tail segment vacated this move is not compared.
- tick outside RUN ignored. grow in DEAD/IDLE ignored. DEAD holds until start.
- Read port: rd_x/rd_y/rd_vld registered from rd_idx, valid in every state; out-of-range index returns 0 with rd_vld=0.

## Timing
- tick at cycle t -> MOVE at t+1, new head visible on head_x/head_y at t+2, CHECK runs len-1 cycles, busy drops after t+1+len.
- Worst-case move latency MAX_LEN cycles; game tick period must exceed it.
- Read latency 1 cycle; read during MOVE returns pre-shift data.
- start during MOVE/CHECK aborts the scan; state RUN next cycle.
- reset mid-operation: immediate return to IDLE values.

## Configuration
- SNAKE_WRAP_EN defined: wall crossing wraps (x=GRID_W-1 +1 -> 0, x=0 -1 -> GRID_W-1, same for y); hit_wall never set.
- Not defined: wall crossing is fatal as above.

## Test plan
- Reset, start -> head (32,24), segments (31,24),(30,24), len=3, dead=0.
- Start, 4 ticks no input -> head (36,24), len=3, busy high exactly len cycles per tick.
- Right, dir=left then dir=up before tick -> left ignored, next tick head y decreases by 1.
- grow once, 6 ticks -> len 3,4,...,8 then stays 8.
- Without SNAKE_WRAP_EN, 32 ticks right -> hit_wall=1, dead=1, head stays (63,24); with macro -> head (0,24), alive.
- len=8, sequence up,left,down -> hit_self=1, dead; start -> flags cleared, len=3.
